// File: rtl/job_mgr_pkg.sv
// rtl/job_mgr_pkg.sv - job manager shared AXI constants and descriptor fetch state encoding
package job_mgr_pkg;
  localparam logic [2:0] AXSIZE_1024B        = 3'd7;
  localparam logic [1:0] AXBURST_INCR        = 2'd1;
  localparam logic [3:0] AXCACHE_NORM_NC_BUF = 4'd3;
  localparam logic [1:0] RESP_OKAY           = 2'b00;
  localparam int unsigned DESC_STRIDE        = 128;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_AR,
    FETCH_R,
    FETCH_PUSH,
    FETCH_UPD
  } fetch_state_e;
endpackage

// File: rtl/job_descriptor_fetch_if.sv
// rtl/job_descriptor_fetch_if.sv - AXI4 read address/data channels used by the descriptor fetcher
interface job_descriptor_fetch_if #(
  parameter int ID_WIDTH     = 1,
  parameter int ARUSER_WIDTH = 9,
  parameter int DATA_WIDTH   = 1024,
  parameter int ADDR_WIDTH   = 64
);
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [3:0]              arcache;
  logic                    arlock;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [ARUSER_WIDTH-1:0] aruser;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arcache, arlock, arprot, arqos, aruser, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arcache, arlock, arprot, arqos, aruser, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/addr_ram.sv
// rtl/addr_ram.sv - distributed RAM, one synchronous write port, asynchronous read port, no reset
module addr_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/job_descriptor_fetch.sv
// rtl/job_descriptor_fetch.sv - per-PASID 128-byte job descriptor fetch over AXI4 read
// Optional saturating error counter output when JOB_DESC_FETCH_ERR_CNT_EN is defined.
module job_descriptor_fetch
  import job_mgr_pkg::*;
#(
  parameter int ID_WIDTH     = 1,
  parameter int ARUSER_WIDTH = 9,
  parameter int PASID_WIDTH  = 9,
  parameter int DATA_WIDTH   = 1024,
  parameter int ADDR_WIDTH   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PASID_WIDTH-1:0] desc_ram_addr_i,
  input  logic                   desc_ram_hi_i,
  input  logic                   desc_ram_lo_i,
  input  logic [31:0]            desc_ram_data_i,
  input  logic                   fetch_valid_i,
  input  logic [PASID_WIDTH-1:0] fetch_pasid_i,
  output logic                   fetch_ready_o,
  output logic                   desc_valid_o,
  input  logic                   desc_ready_i,
  output logic [DATA_WIDTH-1:0]  desc_data_o,
  output logic [PASID_WIDTH-1:0] desc_pasid_o,
  output logic                   fetch_err_o,
  job_descriptor_fetch_if.master m_axi
`ifdef JOB_DESC_FETCH_ERR_CNT_EN
  ,
  output logic [15:0]            err_count_o
`endif
);
  fetch_state_e           state_q, state_d;
  logic [PASID_WIDTH-1:0] pasid_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   err_q;
  logic                   mmio_hit_q;
  logic                   mmio_we;
  logic                   upd_we;
  logic                   r_done;
  logic                   r_ok;
  logic [31:0]            ptr_hi, ptr_lo;
  logic [63:0]            ptr_rd, ptr_next;
  logic [PASID_WIDTH-1:0] ram_waddr;
  logic                   unused_rid;

  assign unused_rid = ^m_axi.rid;

  assign mmio_we  = desc_ram_hi_i | desc_ram_lo_i;
  assign r_done   = (state_q == FETCH_R) && m_axi.rvalid && m_axi.rlast;
  assign r_ok     = (m_axi.rresp == RESP_OKAY);
  assign ptr_rd   = {ptr_hi, ptr_lo};
  assign ptr_next = ptr_rd + 64'(DESC_STRIDE);

  // MMIO owns the single write port whenever it is active; the advance waits for a free cycle.
  assign upd_we    = (state_q == FETCH_UPD) && !mmio_we && !mmio_hit_q && !rst;
  assign ram_waddr = mmio_we ? desc_ram_addr_i : pasid_q;

  addr_ram #(.ADDR_WIDTH(PASID_WIDTH), .DATA_WIDTH(32)) u_ram_hi (
    .clk   (clk),
    .we    (desc_ram_hi_i | upd_we),
    .waddr (ram_waddr),
    .wdata (desc_ram_hi_i ? desc_ram_data_i : ptr_next[63:32]),
    .raddr (pasid_q),
    .rdata (ptr_hi)
  );

  addr_ram #(.ADDR_WIDTH(PASID_WIDTH), .DATA_WIDTH(32)) u_ram_lo (
    .clk   (clk),
    .we    (desc_ram_lo_i | upd_we),
    .waddr (ram_waddr),
    .wdata (desc_ram_lo_i ? desc_ram_data_i : ptr_next[31:0]),
    .raddr (pasid_q),
    .rdata (ptr_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      err_q      <= 1'b0;
      mmio_hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= r_done && !r_ok;
      // A host rewrite of this PASID's pointer mid-fetch supersedes the auto-advance.
      if (state_q == FETCH_IDLE)
        mmio_hit_q <= 1'b0;
      else if (mmio_we && (desc_ram_addr_i == pasid_q))
        mmio_hit_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == FETCH_IDLE && fetch_valid_i) pasid_q <= fetch_pasid_i;
    if (r_done && r_ok) data_q <= m_axi.rdata;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE: if (fetch_valid_i) state_d = FETCH_AR;
      FETCH_AR:   if (m_axi.arready) state_d = FETCH_R;
      FETCH_R:    if (r_done) state_d = r_ok ? FETCH_PUSH : FETCH_IDLE;
      FETCH_PUSH: if (desc_ready_i) state_d = FETCH_UPD;
      FETCH_UPD:  if (mmio_hit_q || !mmio_we) state_d = FETCH_IDLE;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  assign fetch_ready_o = (state_q == FETCH_IDLE);
  assign desc_valid_o  = (state_q == FETCH_PUSH);
  assign desc_data_o   = data_q;
  assign desc_pasid_o  = pasid_q;
  assign fetch_err_o   = err_q;

  assign m_axi.arvalid = (state_q == FETCH_AR);
  assign m_axi.rready  = (state_q == FETCH_R);
  assign m_axi.araddr  = ADDR_WIDTH'(ptr_rd);
  assign m_axi.aruser  = ARUSER_WIDTH'(pasid_q);
  assign m_axi.arid    = '0;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = AXSIZE_1024B;
  assign m_axi.arburst = AXBURST_INCR;
  assign m_axi.arcache = AXCACHE_NORM_NC_BUF;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arqos   = 4'd0;

`ifdef JOB_DESC_FETCH_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_cnt_q <= 16'd0;
    else if (r_done && !r_ok && err_cnt_q != 16'hFFFF)
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count_o = err_cnt_q;
`endif
endmodule

// File: tb/tb_job_descriptor_fetch.sv
// tb/tb_job_descriptor_fetch.sv - directed plus randomized fetch checks against a pointer-table model
module tb_job_descriptor_fetch;
  typedef logic [1023:0] w_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  desc_ram_addr_i;
  logic        desc_ram_hi_i, desc_ram_lo_i;
  logic [31:0] desc_ram_data_i;
  logic        fetch_valid_i;
  logic [8:0]  fetch_pasid_i;
  logic        fetch_ready_o;
  logic        desc_valid_o;
  logic        desc_ready_i;
  logic [1023:0] desc_data_o;
  logic [8:0]  desc_pasid_o;
  logic        fetch_err_o;
`ifdef JOB_DESC_FETCH_ERR_CNT_EN
  logic [15:0] err_count_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_err_model = 0;
  logic [63:0] model [512];

  job_descriptor_fetch_if #(.ID_WIDTH(1), .ARUSER_WIDTH(9), .DATA_WIDTH(1024), .ADDR_WIDTH(64)) axi ();

  job_descriptor_fetch #(
    .ID_WIDTH(1), .ARUSER_WIDTH(9), .PASID_WIDTH(9), .DATA_WIDTH(1024), .ADDR_WIDTH(64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .desc_ram_addr_i (desc_ram_addr_i),
    .desc_ram_hi_i   (desc_ram_hi_i),
    .desc_ram_lo_i   (desc_ram_lo_i),
    .desc_ram_data_i (desc_ram_data_i),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_pasid_i   (fetch_pasid_i),
    .fetch_ready_o   (fetch_ready_o),
    .desc_valid_o    (desc_valid_o),
    .desc_ready_i    (desc_ready_i),
    .desc_data_o     (desc_data_o),
    .desc_pasid_o    (desc_pasid_o),
    .fetch_err_o     (fetch_err_o),
    .m_axi           (axi)
`ifdef JOB_DESC_FETCH_ERR_CNT_EN
    ,
    .err_count_o     (err_count_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input w_t got, input w_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (low 192 bits)", tag, got[191:0], exp[191:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] rnd1024();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic mmio_wr(input logic [8:0] a, input bit hi, input bit lo, input logic [31:0] d);
    desc_ram_addr_i = a;
    desc_ram_hi_i   = hi;
    desc_ram_lo_i   = lo;
    desc_ram_data_i = d;
    step();
    desc_ram_hi_i = 1'b0;
    desc_ram_lo_i = 1'b0;
    if (hi) model[a][63:32] = d;
    if (lo) model[a][31:0]  = d;
  endtask

  // mode 0: plain advance; 1: MMIO rewrite of the same PASID in UPD; 2: MMIO to PASID mp in UPD
  task automatic do_fetch(input logic [8:0] p, input bit err, input int arw, input int rvw,
                          input int drw, input int mode, input logic [8:0] mp);
    logic [63:0]   ea;
    logic [1023:0] d;
    logic [31:0]   md;
    ea = model[p];
    chk("ready_idle", w_t'(fetch_ready_o), w_t'(1));
    fetch_valid_i = 1'b1;
    fetch_pasid_i = p;
    step();
    fetch_valid_i = 1'b0;
    fetch_pasid_i = 9'($urandom);
    chk("arvalid", w_t'(axi.arvalid), w_t'(1));
    chk("araddr", w_t'(axi.araddr), w_t'(ea));
    chk("aruser", w_t'(axi.aruser), w_t'(p));
    chk("ar_static", w_t'({axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arcache,
                           axi.arlock, axi.arprot, axi.arqos}),
        w_t'({1'b0, 8'd0, 3'd7, 2'd1, 4'd3, 1'b0, 3'd0, 4'd0}));
    chk("ready_busy", w_t'(fetch_ready_o), w_t'(0));
    repeat (arw) step();
    chk("arvalid_hold", w_t'(axi.arvalid), w_t'(1));
    chk("araddr_hold", w_t'(axi.araddr), w_t'(ea));
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
    chk("arvalid_drop", w_t'(axi.arvalid), w_t'(0));
    chk("rready", w_t'(axi.rready), w_t'(1));
    repeat (rvw) step();
    d = rnd1024();
    axi.rvalid = 1'b1;
    axi.rlast  = 1'b1;
    axi.rdata  = d;
    axi.rresp  = err ? 2'b10 : 2'b00;
    step();
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    if (err) begin
      n_err_model++;
      chk("err_pulse", w_t'(fetch_err_o), w_t'(1));
      chk("no_desc_on_err", w_t'(desc_valid_o), w_t'(0));
      chk("ready_after_err", w_t'(fetch_ready_o), w_t'(1));
      step();
      chk("err_pulse_end", w_t'(fetch_err_o), w_t'(0));
      return;
    end
    chk("err_quiet", w_t'(fetch_err_o), w_t'(0));
    chk("desc_valid", w_t'(desc_valid_o), w_t'(1));
    chk("desc_data", desc_data_o, d);
    chk("desc_pasid", w_t'(desc_pasid_o), w_t'(p));
    for (int i = 0; i < drw; i++) begin
      step();
      chk("hold_valid", w_t'(desc_valid_o), w_t'(1));
      chk("hold_data", desc_data_o, d);
      chk("hold_pasid", w_t'(desc_pasid_o), w_t'(p));
      chk("hold_ready_low", w_t'(fetch_ready_o), w_t'(0));
    end
    desc_ready_i = 1'b1;
    step();
    desc_ready_i = 1'b0;
    chk("desc_valid_drop", w_t'(desc_valid_o), w_t'(0));
    chk("ready_upd", w_t'(fetch_ready_o), w_t'(0));
    if (mode == 0) begin
      step();
      model[p] = model[p] + 64'd128;
    end else begin
      md = (mode == 1) ? 32'h2000 : $urandom;
      mmio_wr((mode == 1) ? p : mp, 1'b0, 1'b1, md);
      chk("upd_stall", w_t'(fetch_ready_o), w_t'(0));
      step();
      if (mode == 2) model[p] = model[p] + 64'd128;
    end
    chk("idle_return", w_t'(fetch_ready_o), w_t'(1));
  endtask

  initial begin
    logic [8:0] pl [9];
    logic [8:0] p;
    logic [63:0] ea;
    int hl;

    rst = 1'b1;
    desc_ram_addr_i = '0; desc_ram_hi_i = 1'b0; desc_ram_lo_i = 1'b0; desc_ram_data_i = '0;
    fetch_valid_i = 1'b0; fetch_pasid_i = '0; desc_ready_i = 1'b0;
    axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = 2'b00;
    axi.rlast = 1'b0; axi.rvalid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_arvalid", w_t'(axi.arvalid), w_t'(0));
    chk("rst_rready", w_t'(axi.rready), w_t'(0));
    chk("rst_desc_valid", w_t'(desc_valid_o), w_t'(0));
    chk("rst_fetch_err", w_t'(fetch_err_o), w_t'(0));
    chk("rst_fetch_ready", w_t'(fetch_ready_o), w_t'(1));

    mmio_wr(9'd5, 1'b0, 1'b1, 32'h1000_0000);
    mmio_wr(9'd5, 1'b1, 1'b0, 32'h0000_0001);
    chk("model_p5", w_t'(model[5]), w_t'(64'h1_1000_0000));
    do_fetch(9'd5, 1'b0, 0, 0, 0, 0, 9'd0);
    do_fetch(9'd5, 1'b0, 1, 2, 1, 0, 9'd0);

    mmio_wr(9'd9, 1'b0, 1'b1, 32'hFFFF_FF80);
    mmio_wr(9'd9, 1'b1, 1'b0, 32'h0);
    do_fetch(9'd9, 1'b0, 0, 0, 0, 0, 9'd0);
    chk("model_carry", w_t'(model[9]), w_t'(64'h1_0000_0000));
    do_fetch(9'd9, 1'b0, 0, 0, 0, 0, 9'd0);

    // arready withheld then reset: AR never accepted, so no response is left pending
    ea = model[9];
    fetch_valid_i = 1'b1; fetch_pasid_i = 9'd9;
    step();
    fetch_valid_i = 1'b0;
    repeat (10) step();
    chk("stall_arvalid", w_t'(axi.arvalid), w_t'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_err_model = 0;
    chk("midrst_arvalid", w_t'(axi.arvalid), w_t'(0));
    chk("midrst_idle", w_t'(fetch_ready_o), w_t'(1));
    chk("midrst_ptr", w_t'(model[9]), w_t'(ea));
    do_fetch(9'd9, 1'b0, 0, 0, 0, 0, 9'd0);

    mmio_wr(9'd3, 1'b1, 1'b1, 32'h0000_4000);
    do_fetch(9'd3, 1'b1, 2, 1, 0, 0, 9'd0);
`ifdef JOB_DESC_FETCH_ERR_CNT_EN
    chk("err_count_one", w_t'(err_count_o), w_t'(1));
`endif
    do_fetch(9'd3, 1'b0, 0, 0, 0, 0, 9'd0);
    do_fetch(9'd3, 1'b0, 0, 0, 20, 0, 9'd0);

    do_fetch(9'd5, 1'b0, 0, 0, 0, 1, 9'd0);
    do_fetch(9'd5, 1'b0, 0, 0, 0, 0, 9'd0);
    mmio_wr(9'd7, 1'b1, 1'b1, 32'h0000_8000);
    do_fetch(9'd5, 1'b0, 0, 0, 0, 2, 9'd7);
    do_fetch(9'd5, 1'b0, 0, 0, 0, 0, 9'd0);
    do_fetch(9'd7, 1'b0, 0, 0, 0, 0, 9'd0);

    for (int i = 0; i < 8; i++) pl[i] = 9'(i);
    pl[8] = 9'd511;
    for (int i = 0; i < 9; i++) mmio_wr(pl[i], 1'b1, 1'b1, $urandom);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(3) == 0) begin
        hl = $urandom_range(1, 3);
        mmio_wr(pl[$urandom_range(8)], hl[1], hl[0], $urandom);
      end
      p = pl[$urandom_range(8)];
      do_fetch(p, ($urandom_range(4) == 0), $urandom_range(3), $urandom_range(3),
               $urandom_range(3), 0, 9'd0);
    end
`ifdef JOB_DESC_FETCH_ERR_CNT_EN
    chk("err_count_final", w_t'(err_count_o), w_t'(n_err_model));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/job_descriptor_fetch.md
Name: job_descriptor_fetch

Overview:
- AXI4 read master that fetches 128-byte job descriptors from host memory for a given PASID.
- Per-PASID descriptor pointer held in on-chip distributed RAM, programmed by the MMIO slave in two 32-bit halves.
- Pointer auto-advances by 128 after each successful fetch.
- Sits in job_manager ahead of the job dispatcher; it is the host-to-card counterpart of the completion writer.

Parameters:
- ID_WIDTH, 1, AXI ID width.
- ARUSER_WIDTH, 9, AXI aruser width (carries PASID).
- PASID_WIDTH, 9, PASID width; address-RAM depth is 2**PASID_WIDTH.
- DATA_WIDTH, 1024, AXI data and descriptor width.
- ADDR_WIDTH, 64, AXI address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- desc_ram_addr_i  in  PASID_WIDTH  MMIO pointer-write index
- desc_ram_hi_i  in  1  write desc_ram_data_i to pointer[63:32]
- desc_ram_lo_i  in  1  write desc_ram_data_i to pointer[31:0]
- desc_ram_data_i  in  32  MMIO pointer data
- fetch_valid_i  in  1  fetch request
- fetch_pasid_i  in  PASID_WIDTH  requesting PASID
- fetch_ready_o  out  1  request accepted when valid&ready
- desc_valid_o  out  1  descriptor available
- desc_ready_i  in  1  dispatcher accepts descriptor
- desc_data_o  out  DATA_WIDTH  descriptor
- desc_pasid_o  out  PASID_WIDTH  PASID of descriptor
- fetch_err_o  out  1  one-cycle pulse: read returned non-OKAY
- m_axi_arid/araddr/arlen/arsize/arburst/arcache/arlock/arprot/arqos/aruser  out  AXI widths  read address
- m_axi_arvalid  out  1;  m_axi_arready  in  1
- m_axi_rid  in  ID_WIDTH;  m_axi_rdata  in  DATA_WIDTH;  m_axi_rresp  in  2;  m_axi_rlast  in  1;  m_axi_rvalid  in  1
- m_axi_rready  out  1

Behaviour:
- Reset: state IDLE; arvalid, rready, desc_valid_o, fetch_err_o = 0; fetch_ready_o = 1. Pointer RAM contents are not reset.
- Static AR fields: arid 0, arlen 0, arsize 3'd7, arburst INCR (2'd1), arcache 4'd3, arlock 0, arprot 0, arqos 0.
- Dynamic AR fields: aruser = latched PASID; araddr = RAM read of latched PASID (asynchronous read).
- IDLE: fetch_ready_o=1. On fetch_valid_i, latch the PASID and go to AR (arvalid=1 the next cycle).
- AR: hold arvalid and araddr stable until arready. On arready, drop arvalid and go to R.
- R: rready=1. On rvalid&rlast:
  - rresp==OKAY: latch rdata into desc_data_o, go to PUSH.
  - Otherwise: pulse fetch_err_o, go to IDLE; no push, no pointer advance.
  - rvalid without rlast cannot occur (arlen=0); ignore it.
- PUSH: desc_valid_o=1, data held stable until desc_ready_i, then go to UPD.
- UPD: write pointer+128 (64-bit wrap, carry into [63:32]) to both halves for the latched PASID, then go to IDLE.
  - If an MMIO write is active this cycle, MMIO wins the RAM port; stay in UPD.
  - If any MMIO write during this fetch (AR through UPD) targeted the latched PASID, drop the increment and go to IDLE.
- MMIO writes are accepted every cycle in any state. Simultaneous hi and lo writes update both halves.
- Latency with zero-wait slave and dispatcher: request-accept to arvalid 1 cycle; rvalid to desc_valid_o 1 cycle; IDLE re-entry 1 cycle after desc handshake.
- Exactly one outstanding read.
- Reset mid-transaction returns to IDLE with no pointer write. The bench must not leave a slave response pending across reset.

Optional Feature:
- Macro: JOB_DESC_FETCH_ERR_CNT_EN.
- Defined: adds output err_count_o [15:0], a saturating count of non-OKAY responses (stops at 16'hFFFF), cleared by rst.
- Undefined: port absent, no counter logic.

Decomposition:
- job_mgr_pkg holds AXSIZE_1024B=3'd7, AXBURST_INCR=2'd1, AXCACHE_NORM_NC_BUF=4'd3, DESC_STRIDE=128, the fetch state enum and the RESP_OKAY constant.
- One sub-module: the existing addr_ram distributed RAM, instantiated twice (hi/lo halves). No new sub-module.

Test Plan:
- Pointer write lo=32'h1000_0000, hi=32'h0000_0001 for PASID 5; fetch PASID 5; slave returns OKAY pattern -> araddr 64'h1_1000_0000, aruser 5, one desc with matching data/pasid. Second fetch -> araddr 64'h1_1000_0080.
- Pointer lo=32'hFFFF_FF80, hi=0; fetch twice -> second araddr 64'h1_0000_0000 (carry into hi).
- rresp=SLVERR on fetch of PASID 3 -> fetch_err_o pulse, no desc_valid_o, next fetch reuses same araddr; err_count_o=1 when macro defined.
- Hold desc_ready_i=0 for 20 cycles -> desc_valid_o, data, pasid stable; fetch_ready_o=0 throughout.
- MMIO lo write to PASID 5 in the UPD cycle with value 32'h2000 -> RAM reads 32'h2000, no increment. MMIO write to PASID 7 in UPD -> PASID 5 increment occurs one cycle later.
- arready held low 10 cycles, then rst asserted -> arvalid=0, state IDLE, PASID pointer unchanged.
